led_fade_sequencer: RTL and testbench

Per-channel brightness sequencer for the four board LEDs. Raw switch inputs are synchronised and debounced. Each channel then ramps its brightness level up or down one step per fade tick under a four-state FSM. All channels share one free-running PWM counter that converts levels to LED drive. The block sits between the board switch pins and the LED pins in `top`, replacing direct switch-to-LED passthrough.

---
 rtl/led_fade_sequencer.sv | 172 +++++++++++++++++
 tb/tb_led_fade_sequencer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/led_fade_sequencer.sv
// led_fade_sequencer: four-channel LED brightness fader.
// Switches are synchronised and debounced. Each channel ramps its level
// up or down one step per shared fade tick. A shared PWM counter turns
// the levels into LED drive.
module led_fade_sequencer #(
  parameter int PWM_BITS        = 8,
  parameter int STEP_DIV        = 256,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic [3:0]              SW,
  output logic [3:0]              LED,
  output logic                    LED_USER,
  output logic [4*PWM_BITS-1:0]   BRIGHTNESS
);

  localparam int DIV_W = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
  localparam int DEB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

  localparam logic [PWM_BITS-1:0] LVL_MAX  = {PWM_BITS{1'b1}};
  localparam logic [PWM_BITS-1:0] LVL_ZERO = {PWM_BITS{1'b0}};
  localparam logic [PWM_BITS-1:0] LVL_ONE  = PWM_BITS'(1);
  localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(STEP_DIV - 1);
  localparam logic [DIV_W-1:0]    DIV_ONE  = DIV_W'(1);
  localparam logic [DEB_W-1:0]    DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DEB_W-1:0]    DEB_ONE  = DEB_W'(1);

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_UP   = 2'd1,
    ST_ON   = 2'd2,
    ST_DOWN = 2'd3
  } state_t;

  logic [3:0]                  sync1_q, sync2_q;
  logic [3:0]                  deb_q, deb_d;
  logic [3:0][DEB_W-1:0]       deb_cnt_q, deb_cnt_d;
  logic [DIV_W-1:0]            div_q, div_d;
  logic                        tick_s;
  state_t [3:0]                state_q, state_d;
  logic [3:0][PWM_BITS-1:0]    level_q, level_d;
  logic [PWM_BITS-1:0]         pwm_q, pwm_d;
  logic [3:0]                  led_q, led_d;
  logic                        led_user_q, led_user_d;

  // Two-flop synchroniser for the asynchronous switch pins.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync1_q <= 4'b0000;
      sync2_q <= 4'b0000;
    end else begin
      sync1_q <= SW;
      sync2_q <= sync1_q;
    end
  end

  // Debounce: accept a change only after DEBOUNCE_CYCLES differing samples.
  always_comb begin
    deb_d     = deb_q;
    deb_cnt_d = deb_cnt_q;
    for (int i = 0; i < 4; i++) begin
      if (sync2_q[i] == deb_q[i]) begin
        deb_cnt_d[i] = {DEB_W{1'b0}};
      end else if (deb_cnt_q[i] == DEB_LAST) begin
        deb_d[i]     = ~deb_q[i];
        deb_cnt_d[i] = {DEB_W{1'b0}};
      end else begin
        deb_cnt_d[i] = deb_cnt_q[i] + DEB_ONE;
      end
    end
  end

  // Fade divider: one-cycle tick every STEP_DIV cycles, shared by all channels.
  always_comb begin
    tick_s = (div_q == DIV_LAST);
    if (tick_s) begin
      div_d = {DIV_W{1'b0}};
    end else begin
      div_d = div_q + DIV_ONE;
    end
  end

  // Channel FSMs: direction changes win over a coincident tick; levels saturate.
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    for (int i = 0; i < 4; i++) begin
      case (state_q[i])
        ST_OFF: begin
          if (deb_q[i]) state_d[i] = ST_UP;
          else          state_d[i] = ST_OFF;
        end
        ST_UP: begin
          if (!deb_q[i]) begin
            state_d[i] = ST_DOWN;
          end else if (tick_s) begin
            if (level_q[i] >= (LVL_MAX - LVL_ONE)) begin
              level_d[i] = LVL_MAX;
              state_d[i] = ST_ON;
            end else begin
              level_d[i] = level_q[i] + LVL_ONE;
            end
          end else begin
            state_d[i] = ST_UP;
          end
        end
        ST_ON: begin
          if (!deb_q[i]) state_d[i] = ST_DOWN;
          else           state_d[i] = ST_ON;
        end
        ST_DOWN: begin
          if (deb_q[i]) begin
            state_d[i] = ST_UP;
          end else if (tick_s) begin
            if (level_q[i] <= LVL_ONE) begin
              level_d[i] = LVL_ZERO;
              state_d[i] = ST_OFF;
            end else begin
              level_d[i] = level_q[i] - LVL_ONE;
            end
          end else begin
            state_d[i] = ST_DOWN;
          end
        end
        default: begin
          state_d[i] = ST_OFF;
          level_d[i] = LVL_ZERO;
        end
      endcase
    end
  end

  // PWM compare and busy flag, both registered before driving the pins.
  always_comb begin
    pwm_d      = pwm_q + LVL_ONE;
    led_user_d = 1'b0;
    for (int i = 0; i < 4; i++) begin
      led_d[i] = (pwm_q < level_q[i]);
      if ((state_q[i] == ST_UP) || (state_q[i] == ST_DOWN)) led_user_d = 1'b1;
      else                                                   led_user_d = led_user_d;
    end
  end

  // State registers for debounce, divider, FSMs, levels, PWM and outputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      deb_q      <= 4'b0000;
      deb_cnt_q  <= '0;
      div_q      <= {DIV_W{1'b0}};
      state_q    <= {4{ST_OFF}};
      level_q    <= '0;
      pwm_q      <= LVL_ZERO;
      led_q      <= 4'b0000;
      led_user_q <= 1'b0;
    end else begin
      deb_q      <= deb_d;
      deb_cnt_q  <= deb_cnt_d;
      div_q      <= div_d;
      state_q    <= state_d;
      level_q    <= level_d;
      pwm_q      <= pwm_d;
      led_q      <= led_d;
      led_user_q <= led_user_d;
    end
  end

  assign LED        = led_q;
  assign LED_USER   = led_user_q;
  assign BRIGHTNESS = level_q;

endmodule

// File: tb/tb_led_fade_sequencer.sv
// Directed bench for led_fade_sequencer with PWM_BITS=4, STEP_DIV=4,
// DEBOUNCE_CYCLES=4 (LVL_MAX=15).
module tb_led_fade_sequencer;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [3:0]  SW;
  logic [3:0]  LED;
  logic        LED_USER;
  logic [15:0] BRIGHTNESS;

  int passes = 0;
  int fails  = 0;
  int checks = 0;

  led_fade_sequencer #(
    .PWM_BITS(4),
    .STEP_DIV(4),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .CLK(CLK),
    .RST_N(RST_N),
    .SW(SW),
    .LED(LED),
    .LED_USER(LED_USER),
    .BRIGHTNESS(BRIGHTNESS)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  function automatic logic [3:0] lvl(input int ch);
    return BRIGHTNESS[ch*4 +: 4];
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int cyc;
    int bad;
    int hi;
    int prev;
    int exp_l;

    // 1. Reset with all switches held high.
    SW    = 4'b1111;
    RST_N = 1'b0;
    step(3);
    check("rst_led", LED, 0);
    check("rst_bri", BRIGHTNESS, 0);
    check("rst_user", LED_USER, 0);
    RST_N = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      step(1);
      check("predeb_bri", BRIGHTNESS, 0);
      check("predeb_user", LED_USER, 0);
      check("predeb_led", LED, 0);
    end

    // 5. All four channels ramp together; first tick lands on edge 8.
    for (int k = 0; k <= 56; k++) begin
      step(1);
      exp_l = 1 + k / 4;
      for (int ch = 0; ch < 4; ch++) check("sim_lvl", lvl(ch), exp_l);
      check("sim_user", LED_USER, 1);
    end
    step(1);
    check("sim_user_fall", LED_USER, 0);
    check("sim_full", BRIGHTNESS, 16'hFFFF);

    // 6. Reset in the middle of a ramp on channel 1.
    RST_N = 1'b0;
    SW    = 4'b0010;
    step(2);
    RST_N = 1'b1;
    step(40);
    check("mid_lvl1", lvl(1), 9);
    check("mid_lvl0", lvl(0), 0);
    check("mid_user", LED_USER, 1);
    RST_N = 1'b0;
    #1;
    check("mid_rst_bri", BRIGHTNESS, 0);
    check("mid_rst_user", LED_USER, 0);
    check("mid_rst_led", LED, 0);
    step(2);
    RST_N = 1'b1;
    step(7);
    check("restart_lvl0", lvl(1), 0);
    check("restart_user0", LED_USER, 0);
    step(1);
    check("restart_lvl1", lvl(1), 1);
    check("restart_user1", LED_USER, 1);

    // 2. Debounce reject of a 3-cycle pulse, then acceptance of a held switch.
    RST_N = 1'b0;
    SW    = 4'b0000;
    step(2);
    RST_N = 1'b1;
    step(10);
    SW = 4'b0001;
    step(3);
    SW = 4'b0000;
    for (int k = 0; k < 30; k++) begin
      step(1);
      check("glitch_bri", BRIGHTNESS, 0);
      check("glitch_user", LED_USER, 0);
    end
    SW = 4'b0001;
    step(7);
    check("hold_user0", LED_USER, 0);
    step(1);
    check("hold_user1", LED_USER, 1);

    // 3. Full ramp on channel 0: 14 ticks from level 1 to 15.
    n = 0;
    while (lvl(0) != 4'd1 && n < 12) begin
      step(1);
      n++;
    end
    check("ramp_start", lvl(0), 1);
    cyc  = 0;
    bad  = 0;
    prev = 1;
    while (lvl(0) != 4'd15 && cyc < 100) begin
      step(1);
      cyc++;
      if (!((int'(lvl(0)) == prev) || (int'(lvl(0)) == prev + 1))) bad++;
      prev = int'(lvl(0));
    end
    check("ramp_cycles", cyc, 56);
    check("ramp_mono", bad, 0);
    check("ramp_user_lag", LED_USER, 1);
    step(1);
    check("ramp_user_fall", LED_USER, 0);
    hi = 0;
    for (int k = 0; k < 16; k++) begin
      step(1);
      hi += int'(LED[0]);
    end
    check("duty15", hi, 15);

    // 4. Release channel 2 as it reaches 7; one more tick lands before the
    //    reversal is seen, then it counts down without a jump.
    SW = 4'b0101;
    n  = 0;
    while (lvl(2) != 4'd7 && n < 100) begin
      step(1);
      n++;
    end
    check("rev_reach7", lvl(2), 7);
    SW = 4'b0001;
    for (int k = 1; k <= 36; k++) begin
      step(1);
      if (k < 4)      exp_l = 7;
      else if (k < 8) exp_l = 8;
      else            exp_l = 7 - (k - 8) / 4;
      check("rev_lvl", lvl(2), exp_l);
    end
    check("rev_user_lag", LED_USER, 1);
    step(1);
    check("rev_user_fall", LED_USER, 0);
    hi = 0;
    for (int k = 0; k < 32; k++) begin
      step(1);
      hi += int'(LED[2]);
    end
    check("rev_led_off", hi, 0);
    check("rev_ch0_on", lvl(0), 15);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
